// File: rtl/tdm_slot_scheduler.sv
// Eight-slot TDM scheduler: grants a shared resource to each slot's owner, held until done or budget expiry.
// Latency: enable -> ARB next cycle -> registered grant the cycle after; no backpressure. Borrowing: `SLOT_SCHED_BORROW_EN.
module tdm_slot_scheduler #(
   parameter  int NREQ        = 4,
   parameter  int SLOT_CYCLES = 16,
   localparam int OWN_W       = $clog2(NREQ)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [NREQ-1:0]  req,
   input  logic             done,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_slot,
   input  logic [OWN_W-1:0] cfg_owner,
   output logic [2:0]       slot,
   output logic [NREQ-1:0]  grant,
   output logic             grant_valid,
   output logic             timeout
);
   localparam int TMR_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_GRANT} state_t;

   state_t            r_state;
   logic [2:0]        r_slot;
   logic [NREQ-1:0]   r_grant;
   logic              r_grant_vld;
   logic              r_timeout;
   logic [TMR_W-1:0]  r_timer;
   logic [OWN_W-1:0]  r_table [8];

   logic [OWN_W-1:0]  w_owner;
   logic [OWN_W-1:0]  w_win;
   logic              w_win_vld;
   logic [NREQ-1:0]   w_onehot;
`ifdef SLOT_SCHED_BORROW_EN
   logic [OWN_W-1:0]  r_ptr;
   logic              w_borrow;
   int                w_cand;
`endif

   // Out-of-range owners are dropped; the active grant is already registered, so rewrites of its slot wait for the next visit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) r_table[i] <= OWN_W'(i % NREQ);
      end else if (cfg_we && (int'(cfg_owner) < NREQ)) begin
         r_table[cfg_slot] <= cfg_owner;
      end
   end

   always_comb begin
      w_owner   = r_table[r_slot];
      w_win     = w_owner;
`ifdef SLOT_SCHED_BORROW_EN
      w_borrow  = 1'b0;
      w_cand    = 0;
      if (!req[w_owner]) begin
         for (int k = 1; k <= NREQ; k++) begin
            w_cand = (int'(r_ptr) + k) % NREQ;
            if (!w_borrow && (w_cand != int'(w_owner)) && req[w_cand]) begin
               w_borrow = 1'b1;
               w_win    = OWN_W'(w_cand);
            end
         end
      end
      w_win_vld = req[w_owner] | w_borrow;
`else
      w_win_vld = req[w_owner];
`endif
   end

   assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_slot      <= '0;
         r_grant     <= '0;
         r_grant_vld <= 1'b0;
         r_timeout   <= 1'b0;
         r_timer     <= '0;
`ifdef SLOT_SCHED_BORROW_EN
         r_ptr       <= OWN_W'(NREQ-1);
`endif
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (enable) r_state <= ST_ARB;
            end
            ST_ARB: begin
               if (w_win_vld) begin
                  r_grant     <= w_onehot;
                  r_grant_vld <= 1'b1;
                  r_timer     <= TMR_W'(SLOT_CYCLES-1);
                  r_state     <= ST_GRANT;
`ifdef SLOT_SCHED_BORROW_EN
                  if (w_borrow) r_ptr <= w_win;
`endif
               end else begin
                  r_slot  <= r_slot + 3'd1;
                  r_state <= enable ? ST_ARB : ST_IDLE;
               end
            end
            ST_GRANT: begin
               // done takes priority over an expiring budget, suppressing the timeout pulse.
               if (done || (r_timer == '0)) begin
                  r_grant     <= '0;
                  r_grant_vld <= 1'b0;
                  r_timeout   <= ~done;
                  r_slot      <= r_slot + 3'd1;
                  r_state     <= enable ? ST_ARB : ST_IDLE;
               end else begin
                  r_timer <= r_timer - TMR_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign slot        = r_slot;
   assign grant       = r_grant;
   assign grant_valid = r_grant_vld;
   assign timeout     = r_timeout;
endmodule
